// File: rtl/hmem_sub_pkg.sv
// Shared definitions for the high-memory / IO responder: FSM states,
// IO register offsets and control/status bit positions.
package hmem_sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } hmem_state_e;

  localparam logic [1:0] IO_TLOAD = 2'd0;
  localparam logic [1:0] IO_TCNT  = 2'd1;
  localparam logic [1:0] IO_TCTRL = 2'd2;
  localparam logic [1:0] IO_TSTAT = 2'd3;

  localparam int TCTRL_EN  = 0;
  localparam int TCTRL_IRQ = 1;
  localparam int TSTAT_EXP = 0;
  localparam int TSTAT_ERR = 1;

endpackage

// File: rtl/hmem_sub_timer.sv
// Prescaled 8-bit down-counter. Reloads from TLOAD when it reaches the
// end of a period and flags that reload on expired_o for one cycle.
module hmem_sub_timer #(
  parameter int PRESCALE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic [7:0] tload_i,
  output logic [7:0] tcnt_o,
  output logic       expired_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    tcnt_q, tcnt_d;
  logic          wrap;

  assign wrap   = en_i && (pre_q == PW'(PRESCALE - 1));
  assign tcnt_o = tcnt_q;

  // Next prescaler/count; a software load wins over a same-cycle wrap.
  always_comb begin
    pre_d     = pre_q;
    tcnt_d    = tcnt_q;
    expired_o = 1'b0;
    if (load_i) begin
      pre_d  = '0;
      tcnt_d = load_val_i;
    end else if (wrap) begin
      pre_d = '0;
      if (tcnt_q <= 8'd1) begin
        tcnt_d    = tload_i;
        expired_o = 1'b1;
      end else begin
        tcnt_d = tcnt_q - 8'd1;
      end
    end else if (en_i) begin
      pre_d = pre_q + PW'(1);
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q  <= '0;
      tcnt_q <= '0;
    end else begin
      pre_q  <= pre_d;
      tcnt_q <= tcnt_d;
    end
  end

endmodule

// File: rtl/hmem_sub.sv
// Data-bus responder for addresses 0100-ffff: high RAM window, timer IO
// registers, programmable wait states and a level IRQ.
module hmem_sub
  import hmem_sub_pkg::*;
#(
  parameter logic [15:0] RAM_BASE = 16'h0100,
  parameter int          RAM_AW   = 10,
  parameter logic [15:0] IO_BASE  = 16'hff00,
  parameter int          WAIT     = 1,
  parameter int          PRESCALE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        wreq,
  input  logic [7:0]  wdata,
  input  logic        rreq,
  output logic [7:0]  rdata,
  output logic        ack,
  output logic        irq
);

  localparam int CW = (WAIT > 1) ? $clog2(WAIT) : 1;

  hmem_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [15:0]   addr_q;
  logic [7:0]    wdata_q;
  logic          wr_q;

  logic [7:0]    mem_q [2**RAM_AW];
  logic [7:0]    tload_q, tload_d;
  logic [1:0]    tctrl_q, tctrl_d;
  logic [1:0]    tstat_q, tstat_d;
  logic [1:0]    tclr;
  logic          irq_q;

  logic              req_vis, commit, do_wr, ram_hit, io_hit, berr_set;
  logic              t_load, t_expired;
  logic [7:0]        tcnt, rd_val;
  logic [RAM_AW-1:0] ram_idx;

  assign req_vis  = (rreq || wreq) && (|addr[15:8]);
  assign commit   = (state_q == S_ACK);
  assign do_wr    = commit && wr_q;
  assign ram_hit  = ({16'h0, addr_q} >= {16'h0, RAM_BASE}) &&
                    ({16'h0, addr_q} < ({16'h0, RAM_BASE} + (32'd1 << RAM_AW)));
  assign io_hit   = !ram_hit && (addr_q[15:2] == IO_BASE[15:2]);
  assign ram_idx  = RAM_AW'(addr_q - RAM_BASE);
  assign berr_set = commit && !ram_hit && !io_hit;
  assign t_load   = do_wr && io_hit && (addr_q[1:0] == IO_TLOAD);
  assign irq      = irq_q;

  hmem_sub_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .en_i       (tctrl_q[TCTRL_EN]),
    .load_i     (t_load),
    .load_val_i (wdata_q),
    .tload_i    (tload_q),
    .tcnt_o     (tcnt),
    .expired_o  (t_expired)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state; dropping both requests during WAIT aborts the access.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_vis) state_d = (WAIT == 0) ? S_ACK : S_WAIT;
      S_WAIT: begin
        if (!(rreq || wreq))  state_d = S_IDLE;
        else if (cnt_q == '0) state_d = S_ACK;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: ack and read data only during the ACK cycle.
  always_comb begin
    ack   = 1'b0;
    rdata = 8'h00;
    if (state_q == S_ACK) begin
      ack   = 1'b1;
      rdata = rd_val;
    end
  end

  // Request latch and wait-state counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
    end else if (state_q == S_IDLE && req_vis) begin
      addr_q  <= addr;
      wdata_q <= wdata;
      wr_q    <= wreq;
      cnt_q   <= CW'((WAIT > 0) ? WAIT - 1 : 0);
    end else if (state_q == S_WAIT) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // Read mux on the latched address; sees pre-write values during ACK.
  always_comb begin
    rd_val = 8'h00;
    if (ram_hit) begin
      rd_val = mem_q[ram_idx];
    end else if (io_hit) begin
      case (addr_q[1:0])
        IO_TLOAD: rd_val = tload_q;
        IO_TCNT:  rd_val = tcnt;
        IO_TCTRL: rd_val = {6'b0, tctrl_q};
        IO_TSTAT: rd_val = {6'b0, tstat_q};
        default:  rd_val = 8'h00;
      endcase
    end
  end

  // High RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (do_wr && ram_hit) mem_q[ram_idx] <= wdata_q;
  end

  // IO register writes; status set events take priority over W1C.
  always_comb begin
    tload_d = tload_q;
    tctrl_d = tctrl_q;
    tclr    = 2'b00;
    if (do_wr && io_hit) begin
      case (addr_q[1:0])
        IO_TLOAD: tload_d = wdata_q;
        IO_TCNT:  ;
        IO_TCTRL: tctrl_d = wdata_q[1:0];
        IO_TSTAT: tclr    = wdata_q[1:0];
        default:  ;
      endcase
    end
    tstat_d[TSTAT_EXP] = t_expired | (tstat_q[TSTAT_EXP] & ~tclr[TSTAT_EXP]);
    tstat_d[TSTAT_ERR] = berr_set  | (tstat_q[TSTAT_ERR] & ~tclr[TSTAT_ERR]);
  end

  // IO registers; irq follows the next status/control so it moves with them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tload_q <= '0;
      tctrl_q <= '0;
      tstat_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      tload_q <= tload_d;
      tctrl_q <= tctrl_d;
      tstat_q <= tstat_d;
      irq_q   <= tstat_d[TSTAT_EXP] & tctrl_d[TCTRL_IRQ];
    end
  end

endmodule
